// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM access arbiter: FSM encoding, address layout
// and the burst address builder.
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_GAP  = 2'd3
  } arb_state_t;

  localparam int BURST_LEN = 512;
  localparam int ADDR_W    = 24;
  localparam int BUF_BIT   = 22;
  localparam int PAGE_MSB  = 21;
  localparam int PAGE_LSB  = $clog2(BURST_LEN);
  localparam int PAGE_W    = PAGE_MSB - PAGE_LSB + 1;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic buf_sel,
                                                  input logic [PAGE_W-1:0] page);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[BUF_BIT] = buf_sel;
    a[PAGE_MSB:PAGE_LSB] = page;
    return a;
  endfunction
endpackage

// File: rtl/frame_buf_tracker.sv
// Ping-pong frame bookkeeping: write/read page counters, buffer selects,
// completed-frame tracking and the writer stall condition.
module frame_buf_tracker
  import sdram_arb_pkg::*;
#(
  parameter int PAGES_PER_FRAME = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_wr_ack,
  input  logic              i_rd_ack,
  input  logic              i_rd_busy,
  input  logic              i_frame_start,
  output logic [PAGE_W-1:0] o_wr_page,
  output logic [PAGE_W-1:0] o_rd_page,
  output logic              o_wr_buf,
  output logic              o_rd_buf,
  output logic              o_rd_valid,
  output logic              o_rd_pending,
  output logic              o_wr_stall,
  output logic              o_frame_done
);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES_PER_FRAME - 1);
  localparam logic [PAGE_W-1:0] PAGE_END  = PAGE_W'(PAGES_PER_FRAME);

  logic [PAGE_W-1:0] r_wr_page;
  logic [PAGE_W-1:0] r_rd_page;
  logic              r_wr_buf;
  logic              r_rd_buf;
  logic              r_done_buf;
  logic              r_rd_valid;
  logic              r_rd_discard;
  logic              r_frame_done;
  logic              w_rd_open;

  assign w_rd_open = (r_rd_page < PAGE_END);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_page    <= '0;
      r_rd_page    <= '0;
      r_wr_buf     <= 1'b0;
      r_rd_buf     <= 1'b0;
      r_done_buf   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_discard <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_wr_ack) begin
        if (r_wr_page == LAST_PAGE) begin
          r_wr_page    <= '0;
          r_done_buf   <= r_wr_buf;
          r_wr_buf     <= ~r_wr_buf;
          r_rd_valid   <= 1'b1;
          r_frame_done <= 1'b1;
        end else begin
          r_wr_page <= r_wr_page + 1'b1;
        end
      end
      // A read still in flight at frame start belongs to the old frame; its ack must not advance the new one.
      if (i_frame_start) begin
        r_rd_page    <= '0;
        r_rd_buf     <= r_done_buf;
        r_rd_discard <= i_rd_busy && !i_rd_ack;
      end else if (i_rd_ack) begin
        if (!r_rd_discard && w_rd_open) r_rd_page <= r_rd_page + 1'b1;
        r_rd_discard <= 1'b0;
      end
    end
  end

  assign o_wr_page    = r_wr_page;
  assign o_rd_page    = r_rd_page;
  assign o_wr_buf     = r_wr_buf;
  assign o_rd_buf     = r_rd_buf;
  assign o_rd_valid   = r_rd_valid;
  assign o_frame_done = r_frame_done;
  assign o_rd_pending = r_rd_valid && w_rd_open;
  assign o_wr_stall   = (r_wr_buf == r_rd_buf) && o_rd_pending;
endmodule

// File: rtl/sdram_access_arbiter.sv
// Arbitrates page bursts between the fill (write) and display (read) FIFOs on
// the single SDRAM controller request port, with ping-pong frame buffering.
module sdram_access_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int PAGES_PER_FRAME = 128,
  parameter int WR_THRESH       = 512,
  parameter int RD_THRESH       = 512,
  parameter int RD_URGENT       = 128,
  parameter int FIFO_UW         = 11,
  parameter int ACK_TIMEOUT     = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [FIFO_UW-1:0] wr_fifo_used_i,
  input  logic [FIFO_UW-1:0] rd_fifo_used_i,
  input  logic               frame_start_i,
  input  logic               sd_ack_i,
  output logic               sd_req_o,
  output logic               sd_wr_o,
  output logic [ADDR_W-1:0]  sd_add_o,
  output logic               wr_buf_o,
  output logic               rd_buf_o,
  output logic               rd_valid_o,
  output logic               wr_frame_done_o,
  output logic               timeout_err_o
);
  localparam int                 TMO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_MAX = TMO_W'(ACK_TIMEOUT);
  localparam logic [FIFO_UW-1:0] WR_LVL  = FIFO_UW'(WR_THRESH);
  localparam logic [FIFO_UW-1:0] RD_LVL  = FIFO_UW'(RD_THRESH);
  localparam logic [FIFO_UW-1:0] URG_LVL = FIFO_UW'(RD_URGENT);

  arb_state_t        r_state;
  logic              r_req;
  logic              r_wr;
  logic [ADDR_W-1:0] r_add;
  logic              r_last_wr;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_tmo_err;

  logic [PAGE_W-1:0] w_wr_page;
  logic [PAGE_W-1:0] w_rd_page;
  logic              w_wr_buf;
  logic              w_rd_buf;
  logic              w_rd_pending;
  logic              w_wr_stall;
  logic              w_in_wait;
  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_urgent;
  logic              w_grant_rd;

  assign w_in_wait = (r_state == ARB_WAIT);
  assign w_wr_elig = (wr_fifo_used_i >= WR_LVL) && !w_wr_stall;
  // Reads are held off during the frame-start cycle so a new grant never uses the stale page/buffer.
  assign w_rd_elig  = w_rd_pending && (rd_fifo_used_i <= RD_LVL) && !frame_start_i;
  assign w_urgent   = (rd_fifo_used_i < URG_LVL);
  assign w_grant_rd = w_rd_elig && (w_urgent || !w_wr_elig || r_last_wr);

  frame_buf_tracker #(
    .PAGES_PER_FRAME(PAGES_PER_FRAME)
  ) u_tracker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_wr_ack     (w_in_wait && sd_ack_i && r_wr),
    .i_rd_ack     (w_in_wait && sd_ack_i && !r_wr),
    .i_rd_busy    (w_in_wait && !r_wr),
    .i_frame_start(frame_start_i),
    .o_wr_page    (w_wr_page),
    .o_rd_page    (w_rd_page),
    .o_wr_buf     (w_wr_buf),
    .o_rd_buf     (w_rd_buf),
    .o_rd_valid   (rd_valid_o),
    .o_rd_pending (w_rd_pending),
    .o_wr_stall   (w_wr_stall),
    .o_frame_done (wr_frame_done_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_req     <= 1'b0;
      r_wr      <= 1'b0;
      r_add     <= '0;
      r_last_wr <= 1'b0;
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      case (r_state)
        // GAP is the single forced low-request cycle after a burst; it arbitrates like IDLE.
        ARB_IDLE, ARB_GAP: begin
          if (w_wr_elig || w_rd_elig) begin
            r_req     <= 1'b1;
            r_wr      <= !w_grant_rd;
            r_add     <= w_grant_rd ? burst_addr(w_rd_buf, w_rd_page)
                                    : burst_addr(w_wr_buf, w_wr_page);
            r_tmo_cnt <= '0;
            r_state   <= ARB_WAIT;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_REQ, ARB_WAIT: begin
          if (sd_ack_i) begin
            r_req     <= 1'b0;
            r_last_wr <= r_wr;
            r_state   <= ARB_GAP;
          end else if (r_tmo_cnt == TMO_MAX) begin
            r_tmo_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign sd_req_o      = r_req;
  assign sd_wr_o       = r_wr;
  assign sd_add_o      = r_add;
  assign wr_buf_o      = w_wr_buf;
  assign rd_buf_o      = w_rd_buf;
  assign timeout_err_o = r_tmo_err;
endmodule
